// File: rtl/nios_mem_tester.sv
// Avalon-MM memory tester: fills DEPTH words with a SEED-scrambled address pattern, reads them
// back and counts mismatches. Define MEM_TESTER_BYTE_LANE_EN to add a byte-lane overwrite pass.
module nios_mem_tester #(
  parameter int unsigned DEPTH = 16384,
  parameter logic [31:0] SEED  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [13:0] first_fail_addr,
  output logic [13:0] address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  output logic        clken,
  input  logic [31:0] readdata
);

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
`ifdef MEM_TESTER_BYTE_LANE_EN
    S_BYTE  = 3'd2,
`endif
    S_READ  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED ^ {2'b00, a, 2'b00, ~a};
  endfunction

  function automatic logic [DATA_W-1:0] expected(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = pattern(a);
`ifdef MEM_TESTER_BYTE_LANE_EN
    return {8'h5A, p[23:0]};
`else
    return p;
`endif
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                clken_q;
  logic [ADDR_W-1:0]   tag_q, tag_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      be_q      <= 4'hF;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
      clken_q   <= 1'b0;
      tag_q     <= '0;
      cmp_vld_q <= 1'b0;
      err_q     <= '0;
      ffa_q     <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      wd_q      <= wd_d;
      clken_q   <= 1'b1;
      tag_q     <= tag_d;
      cmp_vld_q <= cmp_vld_d;
      err_q     <= err_d;
      ffa_q     <= ffa_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, next bus cycle and result bookkeeping
  always_comb begin
    state_d   = state_q;
    addr_d    = '0;
    be_d      = 4'hF;
    cs_d      = 1'b0;
    wr_d      = 1'b0;
    wd_d      = '0;
    tag_d     = tag_q;
    cmp_vld_d = 1'b0;
    err_d     = err_q;
    ffa_d     = ffa_q;
    pass_d    = pass_q;
    done_d    = 1'b0;

    // readdata belongs to the read issued two edges ago, identified by tag_q
    if (cmp_vld_q && (readdata != expected(tag_q))) begin
      if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
      if (err_q == '0) ffa_d = tag_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          err_d   = '0;
          ffa_d   = '0;
          pass_d  = 1'b0;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wd_d    = pattern('0);
        end
      end
      S_FILL: begin
        cs_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
`ifdef MEM_TESTER_BYTE_LANE_EN
          state_d = S_BYTE;
          wr_d    = 1'b1;
          be_d    = 4'b1000;
          wd_d    = {8'h5A, 24'h0};
`else
          state_d = S_READ;
`endif
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          wr_d   = 1'b1;
          wd_d   = pattern(addr_q + ADDR_W'(1));
        end
      end
`ifdef MEM_TESTER_BYTE_LANE_EN
      S_BYTE: begin
        cs_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          wr_d   = 1'b1;
          be_d   = 4'b1000;
          wd_d   = {8'h5A, 24'h0};
        end
      end
`endif
      S_READ: begin
        tag_d     = addr_q;
        cmp_vld_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_CHECK;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cs_d   = 1'b1;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
  assign address         = addr_q;
  assign byteenable      = be_q;
  assign chipselect      = cs_q;
  assign write           = wr_q;
  assign writedata       = wd_q;
  assign clken           = clken_q;

endmodule
